// File: rtl/countdown_hi_stage_pkg.sv
`default_nettype none
// ============================================================================
// countdown_hi_stage_pkg : state encodings for the high-order countdown stage
// Revision: 1.0
// ============================================================================
package countdown_hi_stage_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/countdown_hi_stage_borrow_edge_det.sv
`default_nettype none
// ============================================================================
// borrow_edge_det : rising-edge detector on the low stage's registered borrow
// Revision: 1.0
// ============================================================================
module borrow_edge_det (
  input  logic i_clk,
  input  logic i_mr,
  input  logic i_d,
  output logic o_rise
);

  logic r_d;

  always_ff @(posedge i_clk) begin
    if (i_mr) begin
      r_d <= 1'b0;
    end else begin
      r_d <= i_d;
    end
  end

  // The low stage holds CO while disabled, so only a 0->1 change is a borrow.
  assign o_rise = i_d & ~r_d;

endmodule
`default_nettype wire

// File: rtl/countdown_hi_stage.sv
`default_nettype none
// ============================================================================
// countdown_hi_stage : high-order stage of a chained down counter with expiry
// Revision: 1.0
// ============================================================================
module countdown_hi_stage
  import countdown_hi_stage_pkg::*;
#(
  parameter int HI_W = 4
) (
  input  logic            i_clk,
  input  logic            i_mr,
  input  logic            i_load,
  input  logic [HI_W-1:0] i_preset,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_ack,
  input  logic [3:0]      i_lo_q,
  input  logic            i_lo_co,
  output logic            o_lo_en,
  output logic [HI_W-1:0] o_hi_q,
  output logic            o_busy,
  output logic            o_expired,
  output logic            o_alarm
);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [HI_W-1:0] r_hi_q;
  logic            r_alarm;
  logic            w_zero;
  logic            w_bev;
  logic            w_dec;

  borrow_edge_det u_borrow_edge_det (
    .i_clk  (i_clk),
    .i_mr   (i_mr),
    .i_d    (i_lo_co),
    .o_rise (w_bev)
  );

  assign w_zero = (r_hi_q == '0) && (i_lo_q == 4'd0);
  assign w_dec  = w_bev && (r_hi_q != '0);

  always_ff @(posedge i_clk) begin
    if (i_mr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_PAUSE: begin
        if (!i_load && i_start && !i_stop) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_next_state = ST_PAUSE;
        end else if (w_zero) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_load || i_ack) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    o_expired = (r_state == ST_DONE);
    o_lo_en   = (r_state == ST_RUN) && !w_zero;
  end

  // A borrow landing the cycle after STOP is still taken, hence PAUSE decrements too.
  always_ff @(posedge i_clk) begin
    if (i_mr) begin
      r_hi_q <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_load) r_hi_q <= i_preset;
        end
        ST_RUN: begin
          if (w_dec) r_hi_q <= r_hi_q - HI_W'(1);
        end
        ST_PAUSE: begin
          if (i_load)     r_hi_q <= i_preset;
          else if (w_dec) r_hi_q <= r_hi_q - HI_W'(1);
        end
        default: r_hi_q <= r_hi_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_mr) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= (r_state == ST_RUN) && (w_next_state == ST_DONE);
    end
  end

  assign o_hi_q  = r_hi_q;
  assign o_alarm = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_countdown_hi_stage.sv
`default_nettype none
// ============================================================================
// tb_countdown_hi_stage : bench with a 4-bit down-counter low stage model
// Revision: 1.0
// ============================================================================
module tb_countdown_hi_stage;

  logic       clk = 1'b0;
  logic       mr, load, start, stop, ack;
  logic [3:0] preset;
  logic [3:0] lo_q;
  logic       lo_co;
  logic       lo_en, busy, expired, alarm;
  logic [3:0] hi_q;

  int total = 0;
  int bad   = 0;
  int en_cnt, alarm_cnt;

  always #5 clk = ~clk;

  // Low stage: decrements when enabled, CO registered on wrap, held while disabled.
  always_ff @(posedge clk) begin
    if (mr) begin
      lo_q  <= 4'd0;
      lo_co <= 1'b0;
    end else if (lo_en) begin
      lo_q  <= lo_q - 4'd1;
      lo_co <= (lo_q == 4'd0);
    end
  end

  countdown_hi_stage #(.HI_W(4)) dut (
    .i_clk     (clk),
    .i_mr      (mr),
    .i_load    (load),
    .i_preset  (preset),
    .i_start   (start),
    .i_stop    (stop),
    .i_ack     (ack),
    .i_lo_q    (lo_q),
    .i_lo_co   (lo_co),
    .o_lo_en   (lo_en),
    .o_hi_q    (hi_q),
    .o_busy    (busy),
    .o_expired (expired),
    .o_alarm   (alarm)
  );

  typedef struct {
    logic       load;
    logic [3:0] preset;
    logic       start;
    logic       stop;
    logic       ack;
    logic       busy;
    logic       expired;
    logic       alarm;
    logic [3:0] hi;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (lo_en) en_cnt++;
    if (alarm) alarm_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mr = 1'b1;
    tick();
    mr = 1'b0;
    en_cnt = 0;
    alarm_cnt = 0;
  endtask

  task automatic load_start(input logic [3:0] p);
    load = 1'b1; preset = p;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [3:0] snap_lo, snap_hi;

  initial begin
    mr = 1'b1; preset = 4'd0; en_cnt = 0; alarm_cnt = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("rst_hi_q", 32'(hi_q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_lo_en", 32'(lo_en), 32'd0);

    // Control-path vectors, one per cycle, starting from IDLE with LO_Q=0
    //           load  pre    start stop  ack   busy  exp   alm   hi
    vecs[0] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5};
    vecs[1] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[2] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[3] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[4] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[5] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[6] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[7] = '{1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9};
    vecs[8] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9};
    vecs[9] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9};
    for (int i = 0; i < 10; i++) begin
      load = vecs[i].load; preset = vecs[i].preset;
      start = vecs[i].start; stop = vecs[i].stop; ack = vecs[i].ack;
      tick();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].expired));
      check($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(vecs[i].alarm));
      check($sformatf("vec%0d_hi_q", i), 32'(hi_q), 32'(vecs[i].hi));
    end
    idle_inputs();

    // PRESET=2 full run: 32 enabled cycles, single alarm
    do_reset();
    load_start(4'd2);
    repeat (60) tick();
    check("run2_en_cycles", 32'(en_cnt), 32'd32);
    check("run2_alarm_cnt", 32'(alarm_cnt), 32'd1);
    check("run2_expired", 32'(expired), 32'd1);
    check("run2_hi_q", 32'(hi_q), 32'd0);
    check("run2_lo_q", 32'(lo_q), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_expired", 32'(expired), 32'd0);
    check("ack_busy", 32'(busy), 32'd0);

    // PRESET=1 with pause at LO_Q=5
    do_reset();
    load_start(4'd1);
    for (int i = 0; i < 40 && lo_q != 4'd5; i++) tick();
    check("pause_reach_lo5", 32'(lo_q), 32'd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    snap_lo = lo_q;
    snap_hi = hi_q;
    repeat (10) tick();
    check("pause_lo_frozen", 32'(lo_q), 32'(snap_lo));
    check("pause_hi_frozen", 32'(hi_q), 32'(snap_hi));
    check("pause_busy", 32'(busy), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("pause_en_cycles", 32'(en_cnt), 32'd16);
    check("pause_expired", 32'(expired), 32'd1);
    check("pause_alarm_cnt", 32'(alarm_cnt), 32'd1);

    // Zero total at START: DONE next edge, LO_EN never rises
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_run_busy", 32'(busy), 32'd1);
    check("zero_run_lo_en", 32'(lo_en), 32'd0);
    tick();
    check("zero_expired", 32'(expired), 32'd1);
    check("zero_alarm", 32'(alarm), 32'd1);
    tick();
    check("zero_alarm_drop", 32'(alarm), 32'd0);
    check("zero_still_expired", 32'(expired), 32'd1);
    check("zero_en_cycles", 32'(en_cnt), 32'd0);
    load = 1'b1; preset = 4'd4;
    tick();
    load = 1'b0;
    check("done_load_expired", 32'(expired), 32'd0);
    check("done_load_busy", 32'(busy), 32'd0);
    check("done_load_hi_q", 32'(hi_q), 32'd4);

    // Reset mid-run
    do_reset();
    load_start(4'd3);
    repeat (20) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    mr = 1'b1;
    tick();
    mr = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hi_q", 32'(hi_q), 32'd0);
    check("mid_rst_lo_en", 32'(lo_en), 32'd0);
    repeat (5) tick();
    check("mid_rst_no_alarm", 32'(alarm_cnt), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
